// File: rtl/iicmb_txn_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : iicmb_txn_sequencer_if
// Brief  : Wishbone master-side bus plus IICMB interrupt line.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface iicmb_txn_sequencer_if #(
  parameter int WB_ADDR_WIDTH = 2,
  parameter int WB_DATA_WIDTH = 8
);
  logic                     cyc_o;
  logic                     stb_o;
  logic                     we_o;
  logic [WB_ADDR_WIDTH-1:0] adr_o;
  logic [WB_DATA_WIDTH-1:0] dat_o;
  logic [WB_DATA_WIDTH-1:0] dat_i;
  logic                     ack_i;
  logic                     irq_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  dat_i, ack_i, irq_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output dat_i, ack_i, irq_i
  );
endinterface

`default_nettype wire

// File: rtl/iicmb_txn_sequencer.sv
//------------------------------------------------------------------------------
// Module : iicmb_txn_sequencer
// Brief  : Runs a whole I2C transaction on the IICMB core over Wishbone.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iicmb_txn_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 8
) (
  input  wire                       clk_i,
  input  wire                       rst_n_i,
  input  wire                       req_valid_i,
  output logic                      req_ready_o,
  input  wire  [3:0]                req_bus_i,
  input  wire  [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  wire                       req_rd_i,
  input  wire  [LEN_WIDTH-1:0]      req_len_i,
  input  wire                       wdata_valid_i,
  input  wire  [WB_DATA_WIDTH-1:0]  wdata_i,
  output logic                      wdata_ready_o,
  output logic                      rdata_valid_o,
  output logic [WB_DATA_WIDTH-1:0]  rdata_o,
  output logic                      done_o,
  output logic [1:0]                err_o,
  iicmb_txn_sequencer_if.master     wb
);

  localparam logic [WB_ADDR_WIDTH-1:0] c_adr_csr  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] c_adr_dpr  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] c_adr_cmdr = WB_ADDR_WIDTH'(2);

  localparam logic [2:0] c_cmd_set_bus   = 3'b110;
  localparam logic [2:0] c_cmd_start     = 3'b100;
  localparam logic [2:0] c_cmd_write     = 3'b001;
  localparam logic [2:0] c_cmd_stop      = 3'b101;
  localparam logic [2:0] c_cmd_read_ack  = 3'b010;
  localparam logic [2:0] c_cmd_read_nack = 3'b011;

  localparam logic [1:0] c_err_ok  = 2'b00;
  localparam logic [1:0] c_err_nak = 2'b01;
  localparam logic [1:0] c_err_al  = 2'b10;
  localparam logic [1:0] c_err_err = 2'b11;

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_SETBUS, S_CMD_WR, S_CMD_IRQ, S_CMD_RD,
    S_EVAL, S_ADDR, S_WD_WAIT, S_WD_DPR, S_RD_DPR, S_FIN
  } state_t;

  typedef enum logic [2:0] {
    PH_SETBUS, PH_START, PH_ADDR, PH_DATA, PH_STOP
  } phase_t;

  state_t                    r_state, w_next;
  phase_t                    r_phase, w_ph_val;
  logic [2:0]                r_cmd, w_cmd_val, w_rd_cmd;
  logic [LEN_WIDTH-1:0]      r_cnt;
  logic [3:0]                r_bus;
  logic [I2C_ADDR_WIDTH-1:0] r_addr;
  logic                      r_rd;
  logic [1:0]                r_err, w_err_val;
  logic [2:0]                r_stat;  // {NAK, AL, ERR}
  logic [WB_DATA_WIDTH-1:0]  r_wbyte;
  logic                      r_enabled;
  logic                      r_cyc, r_we;
  logic [WB_ADDR_WIDTH-1:0]  r_adr, w_adr;
  logic [WB_DATA_WIDTH-1:0]  r_dat, w_dat;
  logic [WB_DATA_WIDTH-1:0]  r_rdata;
  logic                      r_rdata_vld;
  logic                      w_acc, w_we, w_ack;
  logic                      w_cmd_ld, w_cnt_dec, w_err_ld, w_req_ld, w_wbyte_ld;
  logic                      w_ready, w_wready, w_done;

  assign w_ack    = r_cyc & wb.ack_i;
  assign w_rd_cmd = (r_cnt == LEN_WIDTH'(1)) ? c_cmd_read_nack : c_cmd_read_ack;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_INIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_acc      = 1'b0;
    w_we       = 1'b0;
    w_adr      = c_adr_csr;
    w_dat      = '0;
    w_cmd_ld   = 1'b0;
    w_cmd_val  = r_cmd;
    w_ph_val   = r_phase;
    w_cnt_dec  = 1'b0;
    w_err_ld   = 1'b0;
    w_err_val  = r_err;
    w_req_ld   = 1'b0;
    w_wbyte_ld = 1'b0;
    w_ready    = 1'b0;
    w_wready   = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_INIT: begin
        w_acc = 1'b1;
        w_we  = 1'b1;
        w_adr = c_adr_csr;
        w_dat = WB_DATA_WIDTH'(8'hC0);
        if (w_ack) w_next = S_IDLE;
      end
      S_IDLE: begin
        w_ready = r_enabled;
        if (req_valid_i && r_enabled) begin
          w_req_ld = 1'b1;
          w_next   = S_SETBUS;
        end
      end
      S_SETBUS: begin
        w_acc = 1'b1;
        w_we  = 1'b1;
        w_adr = c_adr_dpr;
        w_dat = WB_DATA_WIDTH'(r_bus);
        if (w_ack) begin
          w_cmd_ld  = 1'b1;
          w_cmd_val = c_cmd_set_bus;
          w_ph_val  = PH_SETBUS;
          w_next    = S_CMD_WR;
        end
      end
      S_CMD_WR: begin
        w_acc = 1'b1;
        w_we  = 1'b1;
        w_adr = c_adr_cmdr;
        w_dat = WB_DATA_WIDTH'(r_cmd);
        if (w_ack) w_next = S_CMD_IRQ;
      end
      S_CMD_IRQ: if (wb.irq_i) w_next = S_CMD_RD;
      S_CMD_RD: begin
        w_acc = 1'b1;
        w_adr = c_adr_cmdr;
        if (w_ack) w_next = S_EVAL;
      end
      S_EVAL: begin
        // Only the first error is kept; AL skips the stop since the bus is lost.
        if (r_stat[1]) begin
          w_err_ld  = (r_err == c_err_ok);
          w_err_val = c_err_al;
          w_next    = S_FIN;
        end else if (r_stat[2] || r_stat[0]) begin
          w_err_ld  = (r_err == c_err_ok);
          w_err_val = r_stat[0] ? c_err_err : c_err_nak;
          if (r_phase == PH_STOP) begin
            w_next = S_FIN;
          end else begin
            w_cmd_ld  = 1'b1;
            w_cmd_val = c_cmd_stop;
            w_ph_val  = PH_STOP;
            w_next    = S_CMD_WR;
          end
        end else begin
          case (r_phase)
            PH_SETBUS: begin
              w_cmd_ld  = 1'b1;
              w_cmd_val = c_cmd_start;
              w_ph_val  = PH_START;
              w_next    = S_CMD_WR;
            end
            PH_START: w_next = S_ADDR;
            PH_ADDR: begin
              w_cmd_ld = 1'b1;
              w_next   = S_CMD_WR;
              if (r_cnt == '0) begin
                w_cmd_val = c_cmd_stop;
                w_ph_val  = PH_STOP;
              end else if (r_rd) begin
                w_cmd_val = w_rd_cmd;
                w_ph_val  = PH_DATA;
                w_cnt_dec = 1'b1;
              end else begin
                w_cmd_ld = 1'b0;
                w_next   = S_WD_WAIT;
              end
            end
            PH_DATA: begin
              if (r_rd) begin
                w_next = S_RD_DPR;
              end else if (r_cnt == '0) begin
                w_cmd_ld  = 1'b1;
                w_cmd_val = c_cmd_stop;
                w_ph_val  = PH_STOP;
                w_next    = S_CMD_WR;
              end else begin
                w_next = S_WD_WAIT;
              end
            end
            default: w_next = S_FIN;
          endcase
        end
      end
      S_ADDR: begin
        w_acc = 1'b1;
        w_we  = 1'b1;
        w_adr = c_adr_dpr;
        w_dat = WB_DATA_WIDTH'({r_addr, r_rd});
        if (w_ack) begin
          w_cmd_ld  = 1'b1;
          w_cmd_val = c_cmd_write;
          w_ph_val  = PH_ADDR;
          w_next    = S_CMD_WR;
        end
      end
      S_WD_WAIT: begin
        w_wready = wdata_valid_i;
        if (wdata_valid_i) begin
          w_wbyte_ld = 1'b1;
          w_next     = S_WD_DPR;
        end
      end
      S_WD_DPR: begin
        w_acc = 1'b1;
        w_we  = 1'b1;
        w_adr = c_adr_dpr;
        w_dat = r_wbyte;
        if (w_ack) begin
          w_cmd_ld  = 1'b1;
          w_cmd_val = c_cmd_write;
          w_ph_val  = PH_DATA;
          w_cnt_dec = 1'b1;
          w_next    = S_CMD_WR;
        end
      end
      S_RD_DPR: begin
        w_acc = 1'b1;
        w_adr = c_adr_dpr;
        if (w_ack) begin
          w_cmd_ld = 1'b1;
          w_next   = S_CMD_WR;
          if (r_cnt == '0) begin
            w_cmd_val = c_cmd_stop;
            w_ph_val  = PH_STOP;
          end else begin
            w_cmd_val = w_rd_cmd;
            w_ph_val  = PH_DATA;
            w_cnt_dec = 1'b1;
          end
        end
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rdata     <= '0;
      r_rdata_vld <= 1'b0;
      r_stat      <= '0;
      r_enabled   <= 1'b0;
      r_bus       <= '0;
      r_addr      <= '0;
      r_rd        <= 1'b0;
      r_cnt       <= '0;
      r_err       <= c_err_ok;
      r_cmd       <= '0;
      r_phase     <= PH_SETBUS;
      r_wbyte     <= '0;
    end else begin
      // Strobes drop on the ack cycle; the next access starts one idle cycle later.
      if (r_cyc) begin
        if (wb.ack_i) r_cyc <= 1'b0;
      end else if (w_acc) begin
        r_cyc <= 1'b1;
        r_we  <= w_we;
        r_adr <= w_adr;
        r_dat <= w_dat;
      end
      r_rdata_vld <= 1'b0;
      if (r_state == S_RD_DPR && w_ack) begin
        r_rdata_vld <= 1'b1;
        r_rdata     <= wb.dat_i;
      end
      if (r_state == S_CMD_RD && w_ack) r_stat <= wb.dat_i[6:4];
      if (r_state == S_INIT && w_ack) r_enabled <= 1'b1;
      if (w_req_ld) begin
        r_bus  <= req_bus_i;
        r_addr <= req_addr_i;
        r_rd   <= req_rd_i;
        r_cnt  <= req_len_i;
        r_err  <= c_err_ok;
      end
      if (w_cmd_ld) begin
        r_cmd   <= w_cmd_val;
        r_phase <= w_ph_val;
      end
      if (w_cnt_dec)  r_cnt   <= r_cnt - LEN_WIDTH'(1);
      if (w_err_ld)   r_err   <= w_err_val;
      if (w_wbyte_ld) r_wbyte <= wdata_i;
    end
  end

  assign req_ready_o   = w_ready;
  assign wdata_ready_o = w_wready;
  assign rdata_valid_o = r_rdata_vld;
  assign rdata_o       = r_rdata;
  assign done_o        = w_done;
  assign err_o         = w_done ? r_err : c_err_ok;

  assign wb.cyc_o = r_cyc;
  assign wb.stb_o = r_cyc;
  assign wb.we_o  = r_we;
  assign wb.adr_o = r_adr;
  assign wb.dat_o = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_iicmb_txn_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_iicmb_txn_sequencer
// Brief  : Scoreboard bench with a behavioural IICMB Wishbone slave.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_iicmb_txn_sequencer;

  logic       clk, rst_n;
  logic       req_valid_i, req_ready_o, req_rd_i;
  logic [3:0] req_bus_i;
  logic [6:0] req_addr_i;
  logic [7:0] req_len_i;
  logic       wdata_valid_i, wdata_ready_o, rdata_valid_o, done_o;
  logic [7:0] wdata_i, rdata_o;
  logic [1:0] err_o;

  iicmb_txn_sequencer_if bus_if ();

  iicmb_txn_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_rd_i(req_rd_i), .req_len_i(req_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o),
    .wb(bus_if.master)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int n_done   = 0;
  int n_rdata  = 0;
  int n_wready = 0;

  logic [10:0] exp_wb[$];   // {we, adr[1:0], dat}; reads carry dat=0
  logic [7:0]  exp_rd[$];
  logic [1:0]  exp_err[$];
  logic [7:0]  wd_q[$];
  logic [7:0]  t_data[$];

  logic [7:0] sl_dpr, sl_status, sl_rd_next;
  int         sl_nak_at, sl_byte, irq_cnt, wait_cnt;
  bit         sl_addr_phase, wd_hs, prev_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Behavioural IICMB slave with random ack latency and delayed irq.
  task automatic sl_access();
    logic [10:0] got;
    got = {bus_if.we_o, bus_if.adr_o, bus_if.we_o ? bus_if.dat_o : 8'h00};
    if (exp_wb.size() == 0) check("wb_extra", got, 11'h7FF);
    else                    check("wb_seq", got, exp_wb.pop_front());
    bus_if.dat_i = 8'h00;
    if (bus_if.we_o) begin
      if (bus_if.adr_o == 2'd1) sl_dpr = bus_if.dat_o;
      if (bus_if.adr_o == 2'd2) begin
        case (bus_if.dat_o[2:0])
          3'b110, 3'b101: sl_status = 8'h80;
          3'b100: begin sl_status = 8'h80; sl_addr_phase = 1'b1; sl_byte = 0; end
          3'b001: begin
            if (sl_addr_phase) begin
              sl_addr_phase = 1'b0;
              sl_status = (sl_dpr[7:1] == 7'h7F) ? 8'h40 : 8'h80;
            end else begin
              sl_byte++;
              sl_status = (sl_byte == sl_nak_at) ? 8'h40 : 8'h80;
            end
          end
          3'b010, 3'b011: begin sl_dpr = sl_rd_next; sl_rd_next++; sl_status = 8'h80; end
          default: sl_status = 8'h10;
        endcase
        irq_cnt = 3;
      end
    end else begin
      if (bus_if.adr_o == 2'd2) begin bus_if.dat_i = sl_status; bus_if.irq_i = 1'b0; end
      if (bus_if.adr_o == 2'd1) bus_if.dat_i = sl_dpr;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bus_if.ack_i = 1'b0;
      bus_if.irq_i = 1'b0;
      irq_cnt = 0;
      wait_cnt = 0;
    end else begin
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) bus_if.irq_i = 1'b1;
      end
      if (bus_if.ack_i) bus_if.ack_i = 1'b0;
      else if (bus_if.cyc_o && bus_if.stb_o) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          bus_if.ack_i = 1'b1;
          wait_cnt = $urandom_range(0, 2);
          sl_access();
        end
      end
    end
  end

  // Output monitor: read data, completion status, write handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) check("ready_after_done", req_ready_o, 1);
      prev_done = done_o;
      if (done_o) begin
        n_done++;
        check("ready_at_done", req_ready_o, 0);
        if (exp_err.size() == 0) check("done_extra", {30'd0, err_o}, 32'hFF);
        else                     check("err", err_o, exp_err.pop_front());
      end
      if (rdata_valid_o) begin
        n_rdata++;
        if (exp_rd.size() == 0) check("rdata_extra", rdata_o, 32'h1FF);
        else                    check("rdata", rdata_o, exp_rd.pop_front());
      end
      wd_hs = wdata_valid_i && wdata_ready_o;
      if (wdata_ready_o) n_wready++;
    end else begin
      prev_done = 1'b0;
      wd_hs = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (wd_hs && wd_q.size() > 0) void'(wd_q.pop_front());
    wd_hs = 1'b0;
    wdata_valid_i = rst_n && (wd_q.size() > 0);
    wdata_i = (wd_q.size() > 0) ? wd_q[0] : 8'h00;
  end

  task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
    exp_wb.push_back({1'b1, a, d});
  endtask
  task automatic exp_r(input logic [1:0] a);
    exp_wb.push_back({1'b0, a, 8'h00});
  endtask
  task automatic exp_cmd(input logic [2:0] c);
    exp_w(2'd2, {5'd0, c});
    exp_r(2'd2);
  endtask

  task automatic build_exp(input bit rd, input logic [3:0] bus, input logic [6:0] addr,
                           input int len, input int nak_at, input bit addr_nak, input logic [7:0] rbase);
    logic [1:0] e;
    e = 2'b00;
    exp_w(2'd1, {4'd0, bus});
    exp_cmd(3'b110);
    exp_cmd(3'b100);
    exp_w(2'd1, {addr, rd});
    exp_cmd(3'b001);
    if (addr_nak) e = 2'b01;
    else begin
      for (int i = 0; i < len; i++) begin
        if (rd) begin
          exp_cmd((i == len - 1) ? 3'b011 : 3'b010);
          exp_r(2'd1);
          exp_rd.push_back(rbase + 8'(i));
        end else begin
          exp_w(2'd1, t_data[i]);
          exp_cmd(3'b001);
          if (i + 1 == nak_at) begin e = 2'b01; break; end
        end
      end
    end
    exp_cmd(3'b101);
    exp_err.push_back(e);
  endtask

  task automatic wait_ready();
    int t = 0;
    @(posedge clk); #1;
    while (!req_ready_o && t < 2000) begin @(posedge clk); #1; t++; end
    check("req_ready", req_ready_o, 1);
  endtask

  task automatic do_req(input logic [3:0] bus, input logic [6:0] addr, input logic rd, input logic [7:0] len);
    wait_ready();
    req_bus_i = bus; req_addr_i = addr; req_rd_i = rd; req_len_i = len;
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("ready_drop", req_ready_o, 0);
  endtask

  task automatic wait_done();
    int start = n_done;
    int t = 0;
    while (n_done == start && t < 20000) begin @(posedge clk); t++; end
    check("done_seen", (n_done > start) ? 1 : 0, 1);
    repeat (4) @(posedge clk);
    check("wb_left", exp_wb.size(), 0);
    check("rd_left", exp_rd.size(), 0);
  endtask

  initial begin
    int wbase, t;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_bus_i = '0; req_addr_i = '0; req_rd_i = 1'b0; req_len_i = '0;
    wdata_valid_i = 1'b0; wdata_i = '0;
    bus_if.ack_i = 1'b0; bus_if.irq_i = 1'b0; bus_if.dat_i = '0;
    sl_dpr = '0; sl_status = '0; sl_rd_next = '0; sl_nak_at = 0; sl_byte = 0;
    sl_addr_phase = 1'b0; irq_cnt = 0; wait_cnt = 0; wd_hs = 1'b0; prev_done = 1'b0;

    // Reset state, then the enable write.
    repeat (3) @(negedge clk);
    check("rst_cyc", bus_if.cyc_o, 0);
    check("rst_stb", bus_if.stb_o, 0);
    check("rst_ready", req_ready_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rvalid", rdata_valid_o, 0);
    exp_w(2'd0, 8'hC0);
    rst_n = 1'b1;
    wait_ready();
    check("init_wb", exp_wb.size(), 0);

    // Single-byte write.
    t_data = '{8'h78};
    wd_q = '{8'h78};
    wbase = n_wready;
    build_exp(1'b0, 4'd5, 7'h22, 1, 0, 1'b0, 8'h00);
    do_req(4'd5, 7'h22, 1'b0, 8'd1);
    wait_done();
    check("wready_cnt_w1", n_wready - wbase, 1);

    // 32-byte read; requests while busy must be ignored.
    sl_rd_next = 8'd100;
    build_exp(1'b1, 4'd5, 7'h22, 32, 0, 1'b0, 8'd100);
    do_req(4'd5, 7'h22, 1'b1, 8'd32);
    repeat (20) @(posedge clk);
    #1 req_valid_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 req_valid_i = 1'b0;
    wait_done();

    // Write of 4 bytes, slave NAKs the second data byte.
    t_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    wd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    sl_nak_at = 2;
    wbase = n_wready;
    build_exp(1'b0, 4'd2, 7'h22, 4, 2, 1'b0, 8'h00);
    do_req(4'd2, 7'h22, 1'b0, 8'd4);
    wait_done();
    check("wready_cnt_nak", n_wready - wbase, 2);
    wd_q.delete();
    sl_nak_at = 0;

    // Address-only probe of an absent slave, write data offered but never taken.
    t_data.delete();
    wd_q = '{8'hEE};
    wbase = n_wready;
    build_exp(1'b0, 4'd1, 7'h7F, 0, 0, 1'b1, 8'h00);
    do_req(4'd1, 7'h7F, 1'b0, 8'd0);
    wait_done();
    check("wready_cnt_probe", n_wready - wbase, 0);
    wd_q.delete();

    // Reset during the tenth byte of a 32-byte read.
    sl_rd_next = 8'd100;
    build_exp(1'b1, 4'd5, 7'h22, 32, 0, 1'b0, 8'd100);
    wbase = n_rdata;
    do_req(4'd5, 7'h22, 1'b1, 8'd32);
    t = 0;
    while (n_rdata - wbase < 9 && t < 5000) begin @(posedge clk); t++; end
    check("rd9_seen", (n_rdata - wbase >= 9) ? 1 : 0, 1);
    t = 0;
    do begin @(posedge clk); #2; t++; end while (!bus_if.cyc_o && t < 100);
    check("cyc_before_rst", bus_if.cyc_o, 1);
    rst_n = 1'b0;
    #1;
    check("rst_cyc_drop", bus_if.cyc_o, 0);
    check("rst_stb_drop", bus_if.stb_o, 0);
    exp_wb.delete(); exp_rd.delete(); exp_err.delete(); wd_q.delete();
    repeat (2) @(negedge clk);
    check("rst_ready_mid", req_ready_o, 0);
    exp_w(2'd0, 8'hC0);
    rst_n = 1'b1;
    t_data = '{8'hA5};
    wd_q = '{8'hA5};
    build_exp(1'b0, 4'd3, 7'h22, 1, 0, 1'b0, 8'h00);
    do_req(4'd3, 7'h22, 1'b0, 8'd1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
